// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with threshold flags, occupancy count,
// simultaneous read/write, selectable first-word-fall-through read mode,
// and both pulsed and sticky overflow/underflow reporting.
//
// Handshake: a write is taken on a rising edge when wr_en is high and the
// FIFO is not full, or when it is full but a read is taken on the same edge.
// A read is taken when rd_en is high and the FIFO is not empty. There is no
// write-to-read bypass: an empty FIFO always rejects a read. Standard mode
// presents each popped word one cycle after the pop, qualified by a
// single-cycle rd_valid. FWFT mode presents the head word continuously while
// rd_valid (= !empty) is high, and rd_en acknowledges it. A request that is
// not taken changes nothing except the error outputs.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_THRESH  = 57,
    parameter int AE_THRESH  = 7,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr,
    output logic [1:0]            err_sticky
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    // Thresholds and depth as unsigned count-width values so every flag is a
    // same-width unsigned compare against the registered count.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ovf_now;
    logic                  unf_now;

    logic                  overflow_q;
    logic                  underflow_q;
    logic [1:0]            sticky_q;
    logic [1:0]            sticky_d;

    // Status flags decode the registered count only, so they never glitch
    // on request inputs.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DEPTH_C);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
    end

    // Accept decisions: a read frees a slot, so a full FIFO still takes a
    // write alongside a read; an empty FIFO never serves a read.
    always_comb begin
        rd_ok   = rd_en && !empty;
        wr_ok   = wr_en && (!full || rd_ok);
        ovf_now = wr_en && !wr_ok;
        unf_now = rd_en && !rd_ok;
    end

    // Next occupancy: unchanged when both or neither operation is taken.
    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky errors: a new error overrides a coincident clear.
    always_comb begin
        sticky_d = err_clr ? 2'b00 : sticky_q;
        sticky_d = sticky_d | {ovf_now, unf_now};
    end

    // Storage array; left uninitialised by reset, written only on accept.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset discards all stored words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count_q <= count_d;
        end
    end

    // Error pulses are registered one cycle after the rejected request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sticky_q    <= 2'b00;
        end else begin
            overflow_q  <= ovf_now;
            underflow_q <= unf_now;
            sticky_q    <= sticky_d;
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign err_sticky = sticky_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; valid whenever anything is stored.
            always_comb begin
                rd_data  = mem[rd_ptr];
                rd_valid = !empty;
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: data lands the cycle after the pop and is
            // held until the next accepted read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            always_comb begin
                rd_data  = rd_data_q;
                rd_valid = rd_valid_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT instance share
// the same stimulus; a queue-based model predicts occupancy, flags, errors
// and read data, and a monitor compares both instances every cycle.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          err_clr;

    logic [DW-1:0] rd_data0,  rd_data1;
    logic          rd_valid0, rd_valid1;
    logic [AW:0]   count0,    count1;
    logic          full0,     full1;
    logic          af0,       af1;
    logic          empty0,    empty1;
    logic          ae0,       ae1;
    logic          ovf0,      ovf1;
    logic          unf0,      unf1;
    logic [1:0]    sticky0,   sticky1;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .count(count0), .full(full0), .almost_full(af0), .empty(empty0),
        .almost_empty(ae0), .overflow(ovf0), .underflow(unf0),
        .err_clr(err_clr), .err_sticky(sticky0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                      .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .count(count1), .full(full1), .almost_full(af1), .empty(empty1),
        .almost_empty(ae1), .overflow(ovf1), .underflow(unf1),
        .err_clr(err_clr), .err_sticky(sticky1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [DW-1:0] m_q[$];      // words currently stored
    logic [DW-1:0] exp_q[$];    // words expected on the standard read port
    logic          m_rdv;
    logic          m_ovf;
    logic          m_unf;
    logic [1:0]    m_sticky;

    int unsigned n_vec;
    int unsigned n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of stimulus at the falling edge and advances the
    // model to the state expected just after the next rising edge.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int  cnt;
        logic rok, wok;
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        cnt = m_q.size();
        rok = r && (cnt != 0);
        wok = w && ((cnt != DEPTH) || rok);
        m_rdv = rok;
        if (rok) exp_q.push_back(m_q.pop_front());
        if (wok) m_q.push_back(d);
        m_ovf = w && !wok;
        m_unf = r && !rok;
        m_sticky = (c ? 2'b00 : m_sticky) | {m_ovf, m_unf};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            int sz;
            sz = m_q.size();
            chk("count", 32'(count0), 32'(sz));
            chk("full", 32'(full0), 32'(sz == DEPTH));
            chk("almost_full", 32'(af0), 32'(sz >= AF));
            chk("empty", 32'(empty0), 32'(sz == 0));
            chk("almost_empty", 32'(ae0), 32'(sz <= AE));
            chk("overflow", 32'(ovf0), 32'(m_ovf));
            chk("underflow", 32'(unf0), 32'(m_unf));
            chk("err_sticky", 32'(sticky0), 32'(m_sticky));
            chk("rd_valid", 32'(rd_valid0), 32'(m_rdv));
            if (rd_valid0) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 32'(1), 32'(0));
                end else begin
                    chk("rd_data", 32'(rd_data0), 32'(exp_q.pop_front()));
                end
            end
            chk("fwft_count", 32'(count1), 32'(sz));
            chk("fwft_sticky", 32'(sticky1), 32'(m_sticky));
            chk("fwft_rd_valid", 32'(rd_valid1), 32'(sz != 0));
            if (sz != 0) chk("fwft_rd_data", 32'(rd_data1), 32'(m_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_rdv    = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_sticky = 2'b00;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        err_clr  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count0), 32'(0));
        chk("rst_empty", 32'(empty0), 32'(1));
        chk("rst_almost_empty", 32'(ae0), 32'(1));
        chk("rst_full", 32'(full0), 32'(0));
        chk("rst_almost_full", 32'(af0), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid0), 32'(0));
        chk("rst_rd_data", 32'(rd_data0), 32'(0));
        chk("rst_overflow", 32'(ovf0), 32'(0));
        chk("rst_sticky", 32'(sticky0), 32'(0));
        chk("rst_fwft_valid", 32'(rd_valid1), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Fill and drain in order.
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Overflow at full, clear coinciding with a new overflow, then clear.
        for (int i = 0; i < 8; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 8'hAB, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Simultaneous read/write at full, then drain.
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);            // underflow on empty
        // Simultaneous read/write at empty: write taken, read rejected.
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        idle(1);

        // Wrap-around: bring count to 3 and stream 20 paired operations.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, DW'(8'h30 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // FWFT: a word written into the empty FIFO shows up without rd_en.
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Reset mid-stream at count=5, asserted between clock edges.
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("midrst_count", 32'(count0), 32'(0));
        chk("midrst_empty", 32'(empty0), 32'(1));
        chk("midrst_rd_valid", 32'(rd_valid0), 32'(0));
        chk("midrst_fwft_valid", 32'(rd_valid1), 32'(0));
        m_q.delete();
        exp_q.delete();
        m_rdv    = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_sticky = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Randomised traffic with occasional error clears.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
